// File: rtl/wb_irqc_pkg.sv
// wb_irqc_pkg: register map, limits and byte-lane helper shared by the wb_irqc interrupt controller
package wb_irqc_pkg;
  typedef logic [4:0] irqc_off_t;
  localparam irqc_off_t IRQC_RAW = 5'h00;
  localparam irqc_off_t IRQC_PENDING = 5'h04;
  localparam irqc_off_t IRQC_ENABLE = 5'h08;
  localparam irqc_off_t IRQC_MODE = 5'h0C;
  localparam irqc_off_t IRQC_POLARITY = 5'h10;
  localparam irqc_off_t IRQC_ACTIVE = 5'h14;
  localparam irqc_off_t IRQC_SWSET = 5'h18;
  localparam irqc_off_t IRQC_ID = 5'h1C;
  localparam int IRQC_ID_VALID_BIT = 31;
  localparam int IRQC_MAX_SRC = 32;
  function automatic logic [31:0] irqc_lanes(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction
endpackage

// File: rtl/irqc_sync.sv
// irqc_sync: per-bit two-flop synchroniser for interrupt sources asynchronous to the bus clock
module irqc_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;
  always_ff @(posedge clk or posedge rst)
    if (rst) {q, meta} <= '0;
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/wb_irqc.sv
// wb_irqc: Wishbone interrupt controller (enable/mode/polarity/W1C pending/SWSET/ID); define IRQC_SYNC_EN to synchronise async sources
module wb_irqc
  import wb_irqc_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter logic [IRQC_MAX_SRC-1:0] RST_ENABLE = '0,
  parameter logic [IRQC_MAX_SRC-1:0] RST_MODE = '0
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic [4:0]         wb_adr_i,
  input  logic [31:0]        wb_dat_i,
  input  logic [3:0]         wb_sel_i,
  input  logic               wb_we_i,
  input  logic               wb_cyc_i,
  input  logic               wb_stb_i,
  output logic [31:0]        wb_dat_o,
  output logic               wb_ack_o,
  output logic               wb_err_o,
  output logic               wb_rty_o,
  input  logic [NUM_SRC-1:0] irq_src_i,
  output logic [NUM_SRC-1:0] irq_o,
  output logic               irq_any_o
);
  logic [NUM_SRC-1:0] src, n, prev, pending, enable, mode, polarity, active;
  logic [NUM_SRC-1:0] m, d, set_hw, w1c, sw_set;
  logic [31:0] lane_mask, rd;
  irqc_off_t off;
  logic acc, wr, unused;
  function automatic logic [4:0] lowest(input logic [NUM_SRC-1:0] v);
    logic [4:0] r = 5'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) if (v[i]) r = 5'(i);
    return r;
  endfunction
`ifdef IRQC_SYNC_EN
  irqc_sync #(.W(NUM_SRC)) u_sync (.clk(wb_clk_i), .rst(wb_rst_i), .d(irq_src_i), .q(src));
`else
  assign src = irq_src_i;
`endif
  assign wb_err_o = 1'b0;
  assign wb_rty_o = 1'b0;
  assign off = {wb_adr_i[4:2], 2'b00};
  assign acc = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr = acc & wb_we_i;
  assign lane_mask = irqc_lanes(wb_sel_i);
  assign m = lane_mask[NUM_SRC-1:0];
  assign d = wb_dat_i[NUM_SRC-1:0];
  assign n = src ^ polarity;
  assign active = pending & enable;
  assign set_hw = (mode & n & ~prev) | (~mode & n);
  assign w1c = (wr && off == IRQC_PENDING) ? d & m : '0;
  assign sw_set = (wr && off == IRQC_SWSET) ? d & m : '0;
  assign unused = ^{wb_adr_i[1:0], lane_mask, wb_dat_i};
  always_comb begin
    rd = 32'd0;
    case (off)
      IRQC_RAW:      rd = 32'(n);
      IRQC_PENDING:  rd = 32'(pending);
      IRQC_ENABLE:   rd = 32'(enable);
      IRQC_MODE:     rd = 32'(mode);
      IRQC_POLARITY: rd = 32'(polarity);
      IRQC_ACTIVE:   rd = 32'(active);
      IRQC_ID:       rd = {|active, 26'd0, lowest(active)};
      default:       rd = 32'd0;
    endcase
  end
  // hardware set and SWSET are ORed after the clear so they win a same-edge W1C
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      pending <= '0;
      enable <= RST_ENABLE[NUM_SRC-1:0];
      mode <= RST_MODE[NUM_SRC-1:0];
      polarity <= '0;
      prev <= '0;
      wb_ack_o <= 1'b0;
      wb_dat_o <= 32'd0;
      irq_o <= '0;
      irq_any_o <= 1'b0;
    end else begin
      wb_ack_o <= acc;
      if (acc) wb_dat_o <= rd;
      prev <= n;
      pending <= (pending & ~w1c) | set_hw | sw_set;
      if (wr && off == IRQC_ENABLE) enable <= (enable & ~m) | (d & m);
      if (wr && off == IRQC_MODE) mode <= (mode & ~m) | (d & m);
      if (wr && off == IRQC_POLARITY) polarity <= (polarity & ~m) | (d & m);
      irq_o <= active;
      irq_any_o <= |active;
    end
endmodule
